// File: rtl/dispatch_pkg.sv
// Shared definitions for the decode-to-dispatch interface.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: ENT_W, the bit position of every field in a packed decoded
// instruction, the dec_inst_t struct and pack/unpack helpers between
// the flat ENT_W vector and the struct.
package dispatch_pkg;

  localparam int ENT_W = 64;

  // Single-bit flags
  localparam int NOP_BIT  = 63;
  localparam int MWEN_BIT = 62;
  localparam int FWEN_BIT = 61;
  localparam int IWEN_BIT = 60;

  // Multi-bit fields
  localparam int OPC_HI  = 59;
  localparam int OPC_LO  = 54;
  localparam int DOPC_HI = 53;
  localparam int DOPC_LO = 51;
  localparam int REL_HI  = 50;
  localparam int REL_LO  = 47;
  localparam int OPA_HI  = 46;
  localparam int OPA_LO  = 42;
  localparam int OPB_HI  = 41;
  localparam int OPB_LO  = 37;
  localparam int DEST_HI = 36;
  localparam int DEST_LO = 32;
  localparam int PC_HI   = 31;
  localparam int PC_LO   = 0;

  // Field order matches the flat layout, MSB first.
  typedef struct packed {
    logic        i_nop;
    logic        mem_wen;
    logic        float_reg_wen;
    logic        int_reg_wen;
    logic [5:0]  opcode;
    logic [2:0]  detail_opcode;
    logic [3:0]  reg_relation;
    logic [4:0]  operand_a;
    logic [4:0]  operand_b;
    logic [4:0]  dest_reg;
    logic [31:0] pc;
  } dec_inst_t;

  function automatic dec_inst_t unpack_entry(input logic [ENT_W-1:0] e);
    dec_inst_t d;
    d.i_nop         = e[NOP_BIT];
    d.mem_wen       = e[MWEN_BIT];
    d.float_reg_wen = e[FWEN_BIT];
    d.int_reg_wen   = e[IWEN_BIT];
    d.opcode        = e[OPC_HI:OPC_LO];
    d.detail_opcode = e[DOPC_HI:DOPC_LO];
    d.reg_relation  = e[REL_HI:REL_LO];
    d.operand_a     = e[OPA_HI:OPA_LO];
    d.operand_b     = e[OPB_HI:OPB_LO];
    d.dest_reg      = e[DEST_HI:DEST_LO];
    d.pc            = e[PC_HI:PC_LO];
    return d;
  endfunction

  function automatic logic [ENT_W-1:0] pack_entry(input dec_inst_t d);
    logic [ENT_W-1:0] e;
    e                  = '0;
    e[NOP_BIT]         = d.i_nop;
    e[MWEN_BIT]        = d.mem_wen;
    e[FWEN_BIT]        = d.float_reg_wen;
    e[IWEN_BIT]        = d.int_reg_wen;
    e[OPC_HI:OPC_LO]   = d.opcode;
    e[DOPC_HI:DOPC_LO] = d.detail_opcode;
    e[REL_HI:REL_LO]   = d.reg_relation;
    e[OPA_HI:OPA_LO]   = d.operand_a;
    e[OPB_HI:OPB_LO]   = d.operand_b;
    e[DEST_HI:DEST_LO] = d.dest_reg;
    e[PC_HI:PC_LO]     = d.pc;
    return e;
  endfunction

endpackage

// File: rtl/dq_ptr_ctrl.sv
// Pointer/occupancy bookkeeping for the decode queue circular buffer.
// Latency: pointers and count update one cycle after push_n/pop_n.
// Backpressure: in_ready from registered count only (room for two entries).
//
// Ports: clk, rst_n (async active-low), flush (sync clear),
//        push_n/pop_n (entries written to / read from storage, 0..2),
//        rd_ptr, wr_ptr (modulo DEPTH), count (occupancy), in_ready.
module dq_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       push_n,
  input  logic [1:0]       pop_n,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count,
  output logic             in_ready
);

  localparam logic [PTR_W:0] RDY_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  // Pointers are PTR_W bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

  // Only a pair-sized gap admits a push, so decode never has to split a pair.
  assign in_ready = (count <= RDY_MAX);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_MAX)
    else $error("dq_ptr_ctrl: occupancy above DEPTH");

endmodule

// File: rtl/decode_queue.sv
// Dual-issue decoded-instruction queue between decode and dispatch, program order kept.
// Latency: 1 cycle push-to-output (0 cycles from an empty queue when DQ_BYPASS_EN is defined).
// Backpressure: in_ready low unless two free entries exist; dispatch pops 0..2 via dspch_take.
//
// Ports: clk, rst_n (async active-low), flush (sync, highest priority),
//        in_valid1/in_valid2/in_entry1/in_entry2/in_ready (decode side),
//        out_valid1_dspch/out_valid2_dspch/ent1_dspch/ent2_dspch/dspch_take (dispatch side),
//        count (occupancy of stored entries).
// Optional: DQ_BYPASS_EN - empty-queue combinational bypass from decode to dispatch.
module decode_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic [ENT_W-1:0] in_entry1,
  input  logic [ENT_W-1:0] in_entry2,
  output logic             in_ready,
  output logic             out_valid1_dspch,
  output logic             out_valid2_dspch,
  output logic [ENT_W-1:0] ent1_dspch,
  output logic [ENT_W-1:0] ent2_dspch,
  input  logic [1:0]       dspch_take,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);

  dec_inst_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nx1;
  logic [PTR_W-1:0] wr_ptr_nx1;

  logic             push_ok;
  logic [1:0]       n_in;
  logic [1:0]       avail;
  logic [1:0]       take_cl;
  logic [1:0]       store_n;
  logic [1:0]       pop_n;
  logic             skip_first;
  logic [ENT_W-1:0] wr_dat0;
  logic             q_vld1;
  logic             q_vld2;
`ifdef DQ_BYPASS_EN
  logic             byp;
`endif

  assign rd_ptr_nx1 = rd_ptr + PTR_ONE;
  assign wr_ptr_nx1 = wr_ptr + PTR_ONE;
  assign q_vld1     = (count >= CNT_ONE);
  assign q_vld2     = (count >= CNT_TWO);

  always_comb begin
    push_ok    = in_ready & in_valid1 & ~flush;
    n_in       = push_ok ? (in_valid2 ? 2'd2 : 2'd1) : 2'd0;
    // At most the two presented slots can be taken.
    avail      = q_vld2 ? 2'd2 : count[1:0];
    store_n    = n_in;
    skip_first = 1'b0;
`ifdef DQ_BYPASS_EN
    byp = (count == '0) & ~flush;
    if (byp) begin
      avail = n_in;
    end
`endif
    // An over-sized take (including 3) is trimmed to what is actually on offer.
    take_cl = (dspch_take > avail) ? avail : dspch_take;
    pop_n   = take_cl;
`ifdef DQ_BYPASS_EN
    // Bypassed entries consumed this cycle never touch storage; storage is empty.
    if (byp) begin
      pop_n      = 2'd0;
      store_n    = n_in - take_cl;
      skip_first = (take_cl == 2'd1);
    end
`endif
    wr_dat0 = skip_first ? in_entry2 : in_entry1;
  end

  // Storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (store_n != 2'd0) begin
      mem[wr_ptr] <= unpack_entry(wr_dat0);
    end
    if (store_n == 2'd2) begin
      mem[wr_ptr_nx1] <= unpack_entry(in_entry2);
    end
  end

  always_comb begin
    out_valid1_dspch = q_vld1;
    out_valid2_dspch = q_vld2;
    // Zero the slots when empty so reset shows clean outputs despite unreset storage.
    ent1_dspch       = q_vld1 ? pack_entry(mem[rd_ptr])     : '0;
    ent2_dspch       = q_vld2 ? pack_entry(mem[rd_ptr_nx1]) : '0;
`ifdef DQ_BYPASS_EN
    if (byp) begin
      out_valid1_dspch = in_valid1;
      out_valid2_dspch = in_valid1 & in_valid2;
      ent1_dspch       = in_entry1;
      ent2_dspch       = in_entry2;
    end
`endif
  end

  dq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_n   (store_n),
    .pop_n    (pop_n),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .in_ready (in_ready)
  );

  a_v2_needs_v1: assert property (@(posedge clk) disable iff (!rst_n) !(in_valid2 && !in_valid1))
    else $error("decode_queue: in_valid2 without in_valid1");

  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n || flush) dspch_take <= avail)
    else $error("decode_queue: dspch_take exceeds available entries");

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import dispatch_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
`ifdef DQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid1 = 1'b0;
  logic             in_valid2 = 1'b0;
  logic [ENT_W-1:0] in_entry1 = '0;
  logic [ENT_W-1:0] in_entry2 = '0;
  logic             in_ready;
  logic             out_valid1_dspch;
  logic             out_valid2_dspch;
  logic [ENT_W-1:0] ent1_dspch;
  logic [ENT_W-1:0] ent2_dspch;
  logic [1:0]       dspch_take = 2'd0;
  logic [PTR_W:0]   count;

  decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid1        (in_valid1),
    .in_valid2        (in_valid2),
    .in_entry1        (in_entry1),
    .in_entry2        (in_entry2),
    .in_ready         (in_ready),
    .out_valid1_dspch (out_valid1_dspch),
    .out_valid2_dspch (out_valid2_dspch),
    .ent1_dspch       (ent1_dspch),
    .ent2_dspch       (ent2_dspch),
    .dspch_take       (dspch_take),
    .count            (count)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle, queued by the driver, consumed by the monitor.
  typedef struct {
    logic        v1;
    logic        v2;
    logic [63:0] e1;
    logic [63:0] e2;
    int          cnt;
    logic        rdy;
    bit          zero_ents;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_q[$];   // reference model: stored entries, oldest first
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every expectation issued since the previous falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count",      64'(count),            64'(x.cnt));
        chk("in_ready",   64'(in_ready),         64'(x.rdy));
        chk("out_valid1", 64'(out_valid1_dspch), 64'(x.v1));
        chk("out_valid2", 64'(out_valid2_dspch), 64'(x.v2));
        if (x.zero_ents || x.v1) chk("ent1", ent1_dspch, x.e1);
        if (x.zero_ents || x.v2) chk("ent2", ent2_dspch, x.e2);
      end
    end
  end

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {$urandom(), pc};
  endfunction

  function automatic logic [63:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle of stimulus, record the outputs the spec predicts for it,
  // then advance the reference model by that cycle's push/pop/flush.
  task automatic step(input logic iv1, input logic iv2, input logic [63:0] e1,
                      input logic [63:0] e2, input logic [1:0] tk, input logic fl);
    exp_t        x;
    int          occ;
    bit          byp;
    logic [63:0] inc[$];
    @(posedge clk);
    #1;
    in_valid1  = iv1;
    in_valid2  = iv2;
    in_entry1  = e1;
    in_entry2  = e2;
    dspch_take = tk;
    flush      = fl;
    occ = ref_q.size();
    byp = BYP && (occ == 0) && !fl;
    x.cnt       = occ;
    x.rdy       = (occ <= DEPTH - 2);
    x.zero_ents = 1'b0;
    x.e1 = '0;
    x.e2 = '0;
    if (byp) begin
      x.v1 = iv1;
      x.v2 = iv1 && iv2;
      x.e1 = e1;
      x.e2 = e2;
    end else begin
      x.v1 = (occ >= 1);
      x.v2 = (occ >= 2);
      if (occ >= 1) x.e1 = ref_q[0];
      if (occ >= 2) x.e2 = ref_q[1];
    end
    exp_q.push_back(x);
    if (fl) begin
      ref_q.delete();
    end else begin
      if (x.rdy && iv1) begin
        inc.push_back(e1);
        if (iv2) inc.push_back(e2);
      end
      if (byp) begin
        for (int i = 0; i < int'(tk); i++) void'(inc.pop_front());
      end else begin
        for (int i = 0; i < int'(tk); i++) void'(ref_q.pop_front());
      end
      foreach (inc[i]) ref_q.push_back(inc[i]);
    end
  endtask

  task automatic rand_step();
    logic fl, iv1, iv2;
    int   occ, avail;
    fl  = ($urandom_range(0, 29) == 0);
    iv1 = ($urandom_range(0, 3) != 0);
    iv2 = iv1 && ($urandom_range(0, 1) == 1);
    occ = ref_q.size();
    if (BYP && occ == 0 && !fl) avail = iv1 ? (iv2 ? 2 : 1) : 0;
    else avail = (occ > 2) ? 2 : occ;
    step(iv1, iv2, rnd(), rnd(), fl ? 2'd0 : 2'($urandom_range(0, avail)), fl);
  endtask

  task automatic do_reset();
    exp_t x;
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    in_valid1  = 1'b0;
    in_valid2  = 1'b0;
    in_entry1  = '0;
    in_entry2  = '0;
    dspch_take = 2'd0;
    flush      = 1'b0;
    ref_q.delete();
    x.v1 = 1'b0; x.v2 = 1'b0; x.e1 = '0; x.e2 = '0;
    x.cnt = 0; x.rdy = 1'b1; x.zero_ents = 1'b1;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Fill with four pairs; the fourth is accepted at count 6 and fills the queue.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, mk(32'(32'h100 + i * 8)), mk(32'(32'h104 + i * 8)), 2'd0, 1'b0);
    // Full: push ignored while two are taken.
    step(1'b1, 1'b1, mk(32'h120), mk(32'h124), 2'd2, 1'b0);
    step(1'b0, 1'b0, '0, '0, 2'd2, 1'b0);   // expects count 6, ent1 pc 0x108
    step(1'b0, 1'b0, '0, '0, 2'd2, 1'b0);   // down to 2
    // Steady-state push 2 / take 2 across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rnd(), rnd(), 2'd2, 1'b0);
    step(1'b0, 1'b0, '0, '0, 2'd1, 1'b0);   // down to 1
    step(1'b1, 1'b0, mk(32'h200), '0, 2'd1, 1'b0);
    step(1'b1, 1'b1, rnd(), rnd(), 2'd0, 1'b0);   // ent1 pc 0x200, count 1
    step(1'b1, 1'b1, rnd(), rnd(), 2'd0, 1'b0);   // count 3
    step(1'b1, 1'b1, rnd(), rnd(), 2'd0, 1'b1);   // flush at count 5
    step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);         // count 0, in_ready 1
    for (int i = 0; i < 400; i++) rand_step();
    // Build count 3, then reset mid-stream.
    step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 2'd0, 1'b0);
    step(1'b1, 1'b0, rnd(), '0, 2'd0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, mk(32'h300), '0, 2'd0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);   // ent1 pc 0x300
    step(1'b0, 1'b0, '0, '0, 2'd1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
